fast_divider: RTL and testbench

Iterative unsigned divider that pairs with the multiplier datapath to complete the multiply/divide arithmetic unit. It accepts a dividend/divisor pair through a valid/ready handshake. Most operations use a restoring radix-2 loop that produces one quotient bit per cycle. Trivial operations take a 1-cycle fast path: a divisor of zero, or a dividend smaller than the divisor. Results are reported as a registered single-cycle valid pulse with no backpressure, matching the multiplier's product output style.

---
 rtl/fast_divider.sv | 99 +++++++++
 tb/tb_fast_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fast_divider.sv
// Iterative unsigned divider: restoring radix-2 loop, one quotient bit per cycle,
// with a single-cycle fast path for divide-by-zero and dividend < divisor.
module fast_divider #(
  parameter int DIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIN_W-1:0] dividend_i,
  input  logic [DIN_W-1:0] divisor_i,
  input  logic             operands_valid_i,
  output logic             operands_ready_o,
  output logic [DIN_W-1:0] quotient_o,
  output logic [DIN_W-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             result_valid_o
);

  localparam int CNT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state;
  logic [DIN_W-1:0] rem_q;
  logic [DIN_W-1:0] dsr_q;
  logic [DIN_W-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DIN_W:0]   shifted;
  logic [DIN_W:0]   trial;
  logic             qbit;
  logic [DIN_W-1:0] rem_nxt;
  logic [DIN_W-1:0] dsr_nxt;

  assign operands_ready_o = (state == IDLE);

  // The partial remainder stays below the divisor, so DIN_W bits hold it;
  // only the trial subtraction needs the extra sign bit.
  always_comb begin
    shifted = {rem_q, dsr_q[DIN_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    qbit    = ~trial[DIN_W];
    rem_nxt = qbit ? trial[DIN_W-1:0] : shifted[DIN_W-1:0];
    dsr_nxt = (dsr_q << 1) | DIN_W'(qbit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rem_q          <= '0;
      dsr_q          <= '0;
      dvs_q          <= '0;
      cnt_q          <= '0;
      quotient_o     <= '0;
      remainder_o    <= '0;
      div_by_zero_o  <= 1'b0;
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (operands_valid_i) begin
            if (divisor_i == '0) begin
              quotient_o     <= '1;
              remainder_o    <= dividend_i;
              div_by_zero_o  <= 1'b1;
              result_valid_o <= 1'b1;
            end else if (dividend_i < divisor_i) begin
              quotient_o     <= '0;
              remainder_o    <= dividend_i;
              div_by_zero_o  <= 1'b0;
              result_valid_o <= 1'b1;
            end else begin
              rem_q <= '0;
              dsr_q <= dividend_i;
              dvs_q <= divisor_i;
              cnt_q <= CNT_W'(DIN_W - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          dsr_q <= dsr_nxt;
          if (cnt_q == '0) begin
            quotient_o     <= dsr_nxt;
            remainder_o    <= rem_nxt;
            div_by_zero_o  <= 1'b0;
            result_valid_o <= 1'b1;
            state          <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_divider.sv
// Directed self-checking bench for fast_divider (DIN_W = 8).
module tb_fast_divider;

  localparam int DIN_W = 8;
  localparam int FAST  = 1;          // valid seen in the cycle after the accept edge
  localparam int SLOW  = DIN_W + 1;  // valid seen in the cycle after edge E_DIN_W

  logic             clk;
  logic             rst_n;
  logic [DIN_W-1:0] dividend;
  logic [DIN_W-1:0] divisor;
  logic             operands_valid;
  logic             operands_ready;
  logic [DIN_W-1:0] quotient;
  logic [DIN_W-1:0] remainder;
  logic             div_by_zero;
  logic             result_valid;

  int checks = 0;
  int errors = 0;

  fast_divider #(.DIN_W(DIN_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dividend_i       (dividend),
    .divisor_i        (divisor),
    .operands_valid_i (operands_valid),
    .operands_ready_o (operands_ready),
    .quotient_o       (quotient),
    .remainder_o      (remainder),
    .div_by_zero_o    (div_by_zero),
    .result_valid_o   (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic apply(input string tag, input logic [DIN_W-1:0] a, input logic [DIN_W-1:0] b);
    dividend       = a;
    divisor        = b;
    operands_valid = 1'b1;
    chk({tag, "_ready_at_accept"}, 32'(operands_ready), 32'd1);
    @(negedge clk);
    operands_valid = 1'b0;
  endtask

  // Called at the first negedge after the accept edge.
  task automatic expect_result(input string tag, input int lat, input logic [DIN_W-1:0] q,
                               input logic [DIN_W-1:0] r, input logic z);
    int n;
    int low;
    n   = 1;
    low = 0;
    while (!result_valid && n < 40) begin
      if (!operands_ready) low++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_quotient"}, 32'(quotient), 32'(q));
    chk({tag, "_remainder"}, 32'(remainder), 32'(r));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(z));
    chk({tag, "_ready_low_cycles"}, 32'(low), 32'(lat - 1));
    chk({tag, "_ready_after"}, 32'(operands_ready), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse_width"}, 32'(result_valid), 32'd0);
    chk({tag, "_hold_q"}, 32'(quotient), 32'(q));
  endtask

  typedef struct {
    logic [DIN_W-1:0] a;
    logic [DIN_W-1:0] b;
    int               lat;
    logic [DIN_W-1:0] q;
    logic [DIN_W-1:0] r;
    logic             z;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;

    rst_n          = 1'b0;
    dividend       = '0;
    divisor        = '0;
    operands_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(operands_ready), 32'd1);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    apply("s200_7", 8'd200, 8'd7);
    expect_result("s200_7", SLOW, 8'd28, 8'd4, 1'b0);

    apply("f5_9", 8'd5, 8'd9);
    expect_result("f5_9", FAST, 8'd0, 8'd5, 1'b0);
    apply("f13_0", 8'd13, 8'd0);
    expect_result("f13_0", FAST, 8'hFF, 8'd13, 1'b1);

    // Three fast operations on consecutive edges
    dividend = 8'd3; divisor = 8'd4; operands_valid = 1'b1;
    @(negedge clk);
    chk("b2b1_valid", 32'(result_valid), 32'd1);
    chk("b2b1_q", 32'(quotient), 32'd0);
    chk("b2b1_r", 32'(remainder), 32'd3);
    chk("b2b1_dbz", 32'(div_by_zero), 32'd0);
    chk("b2b1_ready", 32'(operands_ready), 32'd1);
    dividend = 8'd0; divisor = 8'd1;
    @(negedge clk);
    chk("b2b2_valid", 32'(result_valid), 32'd1);
    chk("b2b2_q", 32'(quotient), 32'd0);
    chk("b2b2_r", 32'(remainder), 32'd0);
    chk("b2b2_dbz", 32'(div_by_zero), 32'd0);
    chk("b2b2_ready", 32'(operands_ready), 32'd1);
    dividend = 8'd9; divisor = 8'd0;
    @(negedge clk);
    chk("b2b3_valid", 32'(result_valid), 32'd1);
    chk("b2b3_q", 32'(quotient), 32'hFF);
    chk("b2b3_r", 32'(remainder), 32'd9);
    chk("b2b3_dbz", 32'(div_by_zero), 32'd1);
    operands_valid = 1'b0;
    @(negedge clk);
    chk("b2b_end_valid", 32'(result_valid), 32'd0);

    apply("s255_1", 8'd255, 8'd1);
    expect_result("s255_1", SLOW, 8'd255, 8'd0, 1'b0);
    apply("s7_7", 8'd7, 8'd7);
    expect_result("s7_7", SLOW, 8'd1, 8'd0, 1'b0);
    apply("s255_255", 8'd255, 8'd255);
    expect_result("s255_255", SLOW, 8'd1, 8'd0, 1'b0);

    // Valid held through CALC with new operands: second op waits for ready
    dividend = 8'd100; divisor = 8'd3; operands_valid = 1'b1;
    @(negedge clk);
    dividend = 8'd50; divisor = 8'd5;
    seen = 1;
    while (!result_valid && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    chk("hold1_latency", 32'(seen), 32'(SLOW));
    chk("hold1_q", 32'(quotient), 32'd33);
    chk("hold1_r", 32'(remainder), 32'd1);
    @(negedge clk);
    operands_valid = 1'b0;
    chk("hold2_ready_busy", 32'(operands_ready), 32'd0);
    expect_result("hold2", SLOW, 8'd10, 8'd0, 1'b0);

    // Reset in the middle of a slow operation
    apply("rst_mid", 8'd200, 8'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_q", 32'(quotient), 32'd0);
    chk("rstmid_r", 32'(remainder), 32'd0);
    chk("rstmid_dbz", 32'(div_by_zero), 32'd0);
    chk("rstmid_valid", 32'(result_valid), 32'd0);
    chk("rstmid_ready", 32'(operands_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    chk("rstmid_no_pulse", 32'(seen), 32'd0);
    apply("s6_4", 8'd6, 8'd4);
    expect_result("s6_4", SLOW, 8'd1, 8'd2, 1'b0);

    // Zero / max operand corners
    vecs[0] = '{8'd0,   8'd0,   FAST, 8'hFF, 8'd0,   1'b1};
    vecs[1] = '{8'd0,   8'd5,   FAST, 8'd0,  8'd0,   1'b0};
    vecs[2] = '{8'd255, 8'd0,   FAST, 8'hFF, 8'd255, 1'b1};
    vecs[3] = '{8'd254, 8'd255, FAST, 8'd0,  8'd254, 1'b0};
    vecs[4] = '{8'd128, 8'd16,  SLOW, 8'd8,  8'd0,   1'b0};
    vecs[5] = '{8'd201, 8'd10,  SLOW, 8'd20, 8'd1,   1'b0};
    vecs[6] = '{8'd17,  8'd16,  SLOW, 8'd1,  8'd1,   1'b0};
    for (int k = 0; k < 7; k++) begin
      apply($sformatf("v%0d", k), vecs[k].a, vecs[k].b);
      expect_result($sformatf("v%0d", k), vecs[k].lat, vecs[k].q, vecs[k].r, vecs[k].z);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
